// File: rtl/a2d_scan.sv
// ---------------------------------------------------------------------------
// a2d_scan
//   Multi-channel scan sequencer for an ADC128S-style 12-bit SPI converter.
//   Each request (nxt) walks NUM_CH slots. Every slot runs two SPI frames
//   with the same channel command. The first frame only steers the
//   converter's input mux, and its MISO data is ignored. The second frame
//   returns the conversion. The 12-bit result is then written into that
//   slot, either raw or through a first-order IIR. A single pending request
//   is remembered while a scan is running.
//
// Parameters
//   NUM_CH    slots scanned per request (1..8)
//   CH_MAP    converter channel per slot, 3 bits each, slot i at [3i+2:3i]
//   SCLK_DIV  clk cycles per SCLK period (even, >= 4)
//   AVG_SHIFT IIR shift, 0 = raw pass-through (0..3)
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   nxt        scan request strobe
//   MISO       serial data from converter
//   SS_n       converter select, active low
//   SCLK       SPI clock, idles high
//   MOSI       serial command to converter
//   results    smoothed result per slot, slot i at [12i+11:12i]
//   ch_vld     slot i holds at least one conversion
//   busy       scan in progress or queued
//   scan_done  one-clk pulse after the last slot is written
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for nxt or a pending request
// FRAME1 | SPI frame carrying the command; MISO ignored
// GAP    | SS_n high for half an SCLK period between frames / slots
// FRAME2 | SPI frame repeating the command; MISO captured
// UPDATE | one clk: write result of the current slot, pick next slot
// ---------------------------------------------------------------------------
module a2d_scan #(
  parameter int          NUM_CH    = 4,
  parameter logic [23:0] CH_MAP    = 24'h000D60,
  parameter int          SCLK_DIV  = 32,
  parameter int          AVG_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   nxt,
  input  logic                   MISO,
  output logic                   SS_n,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic [12*NUM_CH-1:0]   results,
  output logic [NUM_CH-1:0]      ch_vld,
  output logic                   busy,
  output logic                   scan_done
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DW-1:0] HALF_M1   = DW'(HALF - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);

  // A frame is 34 half-periods: half 0 is setup, halves 1..32 carry the
  // 16 SCLK periods (odd = SCLK low, even = SCLK high), half 33 is hold.
  localparam logic [5:0] H_HOLD = 6'd32;
  localparam logic [5:0] H_LAST = 6'd33;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRAME1 = 3'd1,
    GAP    = 3'd2,
    FRAME2 = 3'd3,
    UPDATE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DW-1:0]     div_cnt;
  logic              tc;
  logic [5:0]        half_idx;
  logic [SW-1:0]     slot;
  logic              gap_f2;
  logic              pending;
  logic [15:0]       tx_sr;
  logic [11:0]       rx_sr;
  logic [11:0]       res_q [NUM_CH];

  logic              frame_end;
  logic [2:0]        cur_ch;
  logic [11:0]       cur_res;
  logic [11:0]       raw;
  logic signed [12:0] diff;
  logic [11:0]       avg_val;

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'b0};
  endfunction

  // half-period timer; terminal count marks every half-period boundary
  assign tc = (div_cnt == '0);

  assign frame_end = ((state == FRAME1) || (state == FRAME2)) && tc &&
                     (half_idx == H_LAST);

  assign busy = (state != IDLE) || pending;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (nxt || pending) state_nxt = FRAME1;
      FRAME1:  if (frame_end)      state_nxt = GAP;
      GAP:     if (tc)             state_nxt = gap_f2 ? FRAME2 : FRAME1;
      FRAME2:  if (frame_end)      state_nxt = UPDATE;
      UPDATE:  state_nxt = (slot == LAST_SLOT) ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // current slot decode
  // ---------------------------------------------------------------------
  always_comb begin
    cur_ch  = CH_MAP[2:0];
    cur_res = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (slot == SW'(i)) begin
        cur_ch  = CH_MAP[3*i +: 3];
        cur_res = res_q[i];
      end
    end
  end

  // IIR step. The shifted difference never overshoots raw, so the 12-bit
  // truncated sum is always the exact result.
  assign raw     = rx_sr;
  assign diff    = $signed({1'b0, raw}) - $signed({1'b0, cur_res});
  assign avg_val = 12'($signed({1'b0, cur_res}) + (diff >>> AVG_SHIFT));

  // ---------------------------------------------------------------------
  // datapath and SPI pins
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= HALF_M1;
      half_idx  <= '0;
      slot      <= '0;
      gap_f2    <= 1'b0;
      pending   <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      MOSI      <= 1'b0;
      ch_vld    <= '0;
      scan_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      scan_done <= 1'b0;

      if ((state == IDLE) || (state == UPDATE) || tc) begin
        div_cnt <= HALF_M1;
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end

      if (nxt && (state != IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (nxt || pending) begin
            pending  <= 1'b0;
            slot     <= '0;
            half_idx <= '0;
            SS_n     <= 1'b0;
            tx_sr    <= cmd_word(CH_MAP[2:0]);
          end
        end

        FRAME1, FRAME2: begin
          if (tc) begin
            half_idx <= half_idx + 6'd1;
            if (half_idx == H_LAST) begin
              SS_n     <= 1'b1;
              SCLK     <= 1'b1;
              MOSI     <= 1'b0;
              half_idx <= '0;
              gap_f2   <= (state == FRAME1);
            end else if (!half_idx[0] && (half_idx != H_HOLD)) begin
              // entering an odd half: SCLK falls, next command bit out
              SCLK  <= 1'b0;
              MOSI  <= tx_sr[15];
              tx_sr <= {tx_sr[14:0], 1'b0};
            end else if (half_idx[0]) begin
              // entering an even half: SCLK rises, sample converter data.
              // Only the last 12 of the 16 bits survive, which is the result.
              SCLK  <= 1'b1;
              rx_sr <= {rx_sr[10:0], MISO};
            end
          end
        end

        GAP: begin
          if (tc) begin
            SS_n     <= 1'b0;
            half_idx <= '0;
            tx_sr    <= cmd_word(cur_ch);
          end
        end

        UPDATE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (slot == SW'(i)) begin
              res_q[i]  <= ch_vld[i] ? avg_val : raw;
              ch_vld[i] <= 1'b1;
            end
          end
          if (slot == LAST_SLOT) begin
            scan_done <= 1'b1;
          end else begin
            slot   <= slot + 1'b1;
            gap_f2 <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign results[12*g +: 12] = res_q[g];
  end

endmodule
